romix_loop_sequencer: RTL and testbench
=======================================

Name: romix_loop_sequencer

Overview:
- Top-level controller for one scrypt ROMix lane.
- Sequences the write loop (V[i] = X; X = BlockMix(X)) and then the read loop (j = Integerify(X) mod N; X = BlockMix(X xor V[j])).
- Drives the scratchpad RAM write/read strobes and addresses, and hand-shakes with the BlockMix core.
- Sits between the lane start/done interface and the BlockMix datapath; it owns the loop index.

Parameters:
- N_LOG2, 10, log2 of scrypt N; iteration count is N = 2^N_LOG2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a full ROMix; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the read loop completes.
- phase  output  2  0 = idle, 1 = write loop, 2 = read loop, 3 = done.
- iter  output  N_LOG2  current loop index i.
- mem_we  output  1  scratchpad write strobe; RAM stores X at mem_addr.
- mem_re  output  1  scratchpad read strobe; data valid one cycle later.
- mem_addr  output  N_LOG2  scratchpad address.
- j_in  input  N_LOG2  low N_LOG2 bits of Integerify(X), supplied by the datapath.
- bm_start  output  1  one-cycle pulse to start a BlockMix.
- bm_xor_sel  output  1  1 = BlockMix input is X xor RAM data, 0 = X.
- bm_done  input  1  BlockMix result valid; X register is updated by the datapath.

Behaviour:
- Reset, and after every return to IDLE:
  - state IDLE; iter = 0; all strobes 0; busy 0; done 0; phase 0; mem_addr 0; bm_xor_sel 0.
- Reset asserted mid-run aborts immediately; the next cycle is IDLE and no further strobes are issued.
- State machine:
  - IDLE: on start -> W_STORE with iter = 0. Otherwise hold.
  - W_STORE: mem_we = 1, mem_addr = iter, for exactly one cycle -> W_MIX.
  - W_MIX: bm_start = 1, bm_xor_sel = 0, for one cycle -> W_WAIT.
  - W_WAIT: hold until bm_done.
    - On bm_done with iter = N-1: iter <= 0 -> R_FETCH.
    - Otherwise: iter <= iter + 1 -> W_STORE.
  - R_FETCH: mem_re = 1, mem_addr = j_in as sampled this cycle; mem_addr registered and held through R_WAIT -> R_MIX.
  - R_MIX: bm_start = 1, bm_xor_sel = 1 (RAM data now valid) -> R_WAIT.
  - R_WAIT: bm_xor_sel held at 1 until bm_done.
    - On bm_done with iter = N-1 -> DONE.
    - Otherwise: iter <= iter + 1 -> R_FETCH.
  - DONE: done = 1 for one cycle -> IDLE; iter cleared.
- phase is 1 in W_*, 2 in R_*, 3 in DONE, 0 in IDLE.
- iter is modulo 2^N_LOG2. It never wraps in normal operation because the loop terminates at N-1.
- Fastest loop cost (bm_done in the first wait cycle): 3 cycles per write iteration, 3 cycles per read iteration.
- Run latency from the start cycle to the done pulse, with bm_done returned the cycle after bm_start: 6N + 1 cycles. The done pulse occupies the DONE state cycle.
- Boundary conditions:
  - start while busy: ignored.
  - bm_done outside W_WAIT/R_WAIT: ignored.
  - bm_done high in the same cycle bm_start is issued: not sampled. Completion is only accepted in the WAIT state.
  - start in the same cycle as reset: reset wins.
  - N_LOG2 = 1 is legal (N = 2).

Optional Feature:
- Macro: ROMIX_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort high in any busy state forces IDLE on the next edge.
  - All strobes are deasserted in that next cycle; done is not pulsed.
  - abort has priority over bm_done and start; reset has priority over abort.
- When undefined: the port does not exist and the behaviour is exactly as above.

Test Plan:
- N_LOG2=2, start pulse, bm_done returned 1 cycle after each bm_start -> mem_we at addresses 0,1,2,3 with bm_xor_sel=0; then 4 reads at the j_in values; done pulse 25 cycles after the start cycle; busy then low.
- Read loop with j_in driven 3,0,3,1 -> mem_re addresses 3,0,3,1; mem_addr stable through each R_WAIT; bm_xor_sel=1 on every read-loop bm_start.
- bm_done delayed 5 cycles, spurious bm_done injected in W_STORE and R_FETCH -> spurious pulses ignored; iter advances only on bm_done in WAIT states; iteration count unchanged.
- start re-asserted during write loop iteration 2 -> no restart; iter continues 2,3; exactly one done.
- reset asserted in R_WAIT at iter=1 -> next cycle IDLE, iter=0, all strobes 0, no done; a following start runs a full clean sequence.
- With ROMIX_SEQ_ABORT_EN: abort in W_MIX at iter=2 -> IDLE next cycle, bm_start not repeated, done never asserted, a new start is accepted.

Source files
------------

// File: rtl/romix_loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : romix_loop_sequencer
// Purpose  : Sequences one scrypt ROMix lane (write loop, then read loop).
//            Optional abort input when ROMIX_SEQ_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module romix_loop_sequencer #(
  parameter int N_LOG2 = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef ROMIX_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [1:0]        phase,
  output logic [N_LOG2-1:0] iter,
  output logic              mem_we,
  output logic              mem_re,
  output logic [N_LOG2-1:0] mem_addr,
  input  logic [N_LOG2-1:0] j_in,
  output logic              bm_start,
  output logic              bm_xor_sel,
  input  logic              bm_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_STORE = 3'd1,
    S_W_MIX   = 3'd2,
    S_W_WAIT  = 3'd3,
    S_R_FETCH = 3'd4,
    S_R_MIX   = 3'd5,
    S_R_WAIT  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [N_LOG2-1:0] C_ITER_LAST = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic [N_LOG2-1:0] r_iter;
  logic [N_LOG2-1:0] w_iter_next;
  logic [N_LOG2-1:0] r_rd_addr;
  logic [N_LOG2-1:0] w_rd_addr_next;
  logic              w_abort;

`ifdef ROMIX_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign iter = r_iter;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_iter    <= w_iter_next;
      r_rd_addr <= w_rd_addr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_iter_next    = r_iter;
    w_rd_addr_next = r_rd_addr;
    busy           = 1'b1;
    done           = 1'b0;
    phase          = 2'd0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = '0;
    bm_start       = 1'b0;
    bm_xor_sel     = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy        = 1'b0;
        w_iter_next = '0;
        if (start) w_state_next = S_W_STORE;
      end
      S_W_STORE: begin
        phase        = 2'd1;
        mem_we       = 1'b1;
        mem_addr     = r_iter;
        w_state_next = S_W_MIX;
      end
      S_W_MIX: begin
        phase        = 2'd1;
        bm_start     = 1'b1;
        w_state_next = S_W_WAIT;
      end
      S_W_WAIT: begin
        phase = 2'd1;
        if (bm_done) begin
          if (r_iter == C_ITER_LAST) begin
            w_iter_next  = '0;
            w_state_next = S_R_FETCH;
          end else begin
            w_iter_next  = r_iter + 1'b1;
            w_state_next = S_W_STORE;
          end
        end
      end
      // Read address comes straight from the datapath this cycle and is
      // latched so the RAM sees a stable address for the rest of the iteration.
      S_R_FETCH: begin
        phase          = 2'd2;
        mem_re         = 1'b1;
        mem_addr       = j_in;
        w_rd_addr_next = j_in;
        w_state_next   = S_R_MIX;
      end
      S_R_MIX: begin
        phase        = 2'd2;
        bm_start     = 1'b1;
        bm_xor_sel   = 1'b1;
        mem_addr     = r_rd_addr;
        w_state_next = S_R_WAIT;
      end
      S_R_WAIT: begin
        phase      = 2'd2;
        bm_xor_sel = 1'b1;
        mem_addr   = r_rd_addr;
        if (bm_done) begin
          if (r_iter == C_ITER_LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_iter_next  = r_iter + 1'b1;
            w_state_next = S_R_FETCH;
          end
        end
      end
      S_DONE: begin
        phase        = 2'd3;
        done         = 1'b1;
        w_iter_next  = '0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_iter_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
      w_iter_next  = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_romix_loop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_romix_loop_sequencer
// Purpose  : Randomized bench for romix_loop_sequencer with iteration-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_romix_loop_sequencer;

  localparam int N_LOG2 = 2;
  localparam int N      = 1 << N_LOG2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done;
  logic [1:0]        phase;
  logic [N_LOG2-1:0] iter, mem_addr, j_in;
  logic              mem_we, mem_re, bm_start, bm_xor_sel, bm_done;
`ifdef ROMIX_SEQ_ABORT_EN
  logic              abort;
`endif

  romix_loop_sequencer #(.N_LOG2(N_LOG2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef ROMIX_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .phase      (phase),
    .iter       (iter),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .j_in       (j_in),
    .bm_start   (bm_start),
    .bm_xor_sel (bm_xor_sel),
    .bm_done    (bm_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus knobs
  int dly_min = 1, dly_max = 1, spur_pct = 0;
  bit jdir = 1'b0;
  int jlist [4] = '{3, 0, 3, 1};

  // Monitor records
  int we_q[$];
  int re_q[$];
  int done_count = 0;
  int done_lat   = 0;
  int bs_count   = 0;
  int start_cyc  = 0;

  // Model: a run is 2N iterations k; each is memory-op, mix, then wait for completion.
  int m_mode = 0;  // 0 idle, 1 running, 2 done cycle
  int m_k = 0, m_slot = 0, m_j = 0;

  always @(negedge clk) begin
    bit run_on, rd;
    run_on = (m_mode == 1);
    rd     = (m_k >= N);
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_mode == 2));
    chk("phase", 32'(phase), (m_mode == 0) ? 32'd0 : (m_mode == 2) ? 32'd3 : (rd ? 32'd2 : 32'd1));
    if (m_mode != 2) chk("iter", 32'(iter), run_on ? 32'(m_k % N) : 32'd0);
    chk("mem_we", 32'(mem_we), 32'(run_on && m_slot == 0 && !rd));
    chk("mem_re", 32'(mem_re), 32'(run_on && m_slot == 0 && rd));
    chk("bm_start", 32'(bm_start), 32'(run_on && m_slot == 1));
    chk("bm_xor_sel", 32'(bm_xor_sel), 32'(run_on && rd && m_slot >= 1));
    if (m_mode == 0)                      chk("addr_idle", 32'(mem_addr), 32'd0);
    else if (run_on && m_slot == 0 && !rd) chk("addr_wr", 32'(mem_addr), 32'(m_k));
    else if (run_on && m_slot == 0)        chk("addr_rd", 32'(mem_addr), 32'(j_in));
    else if (run_on && rd)                 chk("addr_hold", 32'(mem_addr), 32'(m_j));

    if (mem_we) we_q.push_back(int'(mem_addr));
    if (mem_re) re_q.push_back(int'(mem_addr));
    if (bm_start) bs_count++;
    if (done) begin done_count++; done_lat = cyc - start_cyc; end

    if (reset) m_mode = 0;
`ifdef ROMIX_SEQ_ABORT_EN
    else if (abort && m_mode != 0) m_mode = 0;
`endif
    else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_k = 0; m_slot = 0; end
    end else if (m_mode == 2) m_mode = 0;
    else if (m_slot == 0) begin
      if (rd) m_j = int'(j_in);
      m_slot = 1;
    end else if (m_slot == 1) m_slot = 2;
    else if (bm_done) begin
      m_k++;
      m_slot = 0;
      if (m_k == 2 * N) m_mode = 2;
    end
  end

  // BlockMix responder and j_in source
  initial begin
    int pend;
    pend    = 0;
    bm_done = 1'b0;
    j_in    = '0;
    forever begin
      @(posedge clk);
      #1;
      bm_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) bm_done = 1'b1;
      end
      if (bm_start) pend = $urandom_range(dly_max, dly_min);
      if (!bm_done && spur_pct > 0 && $urandom_range(99, 0) < spur_pct) bm_done = 1'b1;
      if (jdir) j_in = (re_q.size() < 4) ? N_LOG2'(jlist[re_q.size()]) : '0;
      else      j_in = N_LOG2'($urandom);
    end
  end

  task automatic kick();
    we_q.delete();
    re_q.delete();
    done_count = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_count == 0 && n < limit) begin @(posedge clk); n++; end
    if (done_count == 0) begin
      errors++; checks++;
      $display("FAIL run_timeout: got no done expected done within %0d cycles", limit);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Waits until the DUT is in the iteration given by (ph, it) and shows bm_start == bs.
  task automatic wait_point(input logic [1:0] ph, input int it, input bit bs, input bit xs);
    int n = 0;
    while (!(phase == ph && int'(iter) == it && bm_start == bs && bm_xor_sel == xs) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      errors++; checks++;
      $display("FAIL wait_point_timeout: got phase %0d iter %0d expected phase %0d iter %0d", phase, iter, ph, it);
    end
  endtask

  initial begin
    int exp_we [4];
    exp_we = '{0, 1, 2, 3};
    reset  = 1'b1;
    start  = 1'b1;  // start together with reset must be ignored
`ifdef ROMIX_SEQ_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_iter", 32'(iter), 32'd0);

    // Directed run: immediate completion, j sequence 3,0,3,1
    jdir = 1'b1;
    kick();
    wait_done(200);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", (i < we_q.size()) ? 32'(we_q[i]) : 32'hdead, 32'(exp_we[i]));
      chk("rd_addr", (i < re_q.size()) ? 32'(re_q[i]) : 32'hdead, 32'(jlist[i]));
    end
    chk("latency", 32'(done_lat), 32'd25);
    chk("done_once", 32'(done_count), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);

    // Slow completion with spurious bm_done pulses
    jdir = 1'b0; dly_min = 5; dly_max = 5; spur_pct = 25;
    kick();
    wait_done(1000);
    chk("slow_writes", 32'(we_q.size()), 32'd4);
    chk("slow_reads", 32'(re_q.size()), 32'd4);
    chk("slow_done", 32'(done_count), 32'd1);
    spur_pct = 0; dly_min = 1; dly_max = 3;

    // start re-asserted during write iteration 2
    kick();
    wait_point(2'd1, 2, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000);
    repeat (30) @(posedge clk);
    #1;
    chk("restart_done", 32'(done_count), 32'd1);
    chk("restart_writes", 32'(we_q.size()), 32'd4);
    chk("restart_idle", 32'(busy), 32'd0);

    // reset in read wait at iter 1
    dly_min = 3; dly_max = 3;
    kick();
    wait_point(2'd2, 1, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_iter", 32'(iter), 32'd0);
    chk("rst_mid_strobes", {29'd0, mem_we, mem_re, bm_start}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_mid_nodone", 32'(done_count), 32'd0);
    dly_min = 1; dly_max = 1;
    kick();
    wait_done(200);
    chk("post_rst_lat", 32'(done_lat), 32'd25);

`ifdef ROMIX_SEQ_ABORT_EN
    begin
      int bs_before;
      kick();
      wait_point(2'd1, 2, 1'b1, 1'b0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      bs_before = bs_count;
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_bs", 32'(bs_count), 32'(bs_before));
      chk("abort_nodone", 32'(done_count), 32'd0);
      kick();
      wait_done(200);
      chk("abort_restart", 32'(done_count), 32'd1);
    end
`endif

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      dly_min  = 1;
      dly_max  = $urandom_range(6, 1);
      spur_pct = $urandom_range(40, 0);
      kick();
      wait_done(2000);
      chk("rand_writes", 32'(we_q.size()), 32'd4);
      chk("rand_reads", 32'(re_q.size()), 32'd4);
      chk("rand_done", 32'(done_count), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
